// File: rtl/curveball_pkg.sv
// Shared constants, ball sprite size table and stage state encoding for the
// curveball video path (also consumed by the ball sprite renderer).
package curveball_pkg;

  localparam int H_ACTIVE  = 640;
  localparam int V_ACTIVE  = 480;
  localparam int Z_STEP    = 50;
  localparam int NUM_ZONES = 20;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_CONVERT    = 2'd1,
    ST_WAIT_FRAME = 2'd2
  } ball_state_e;

  // Sprite edge length in pixels for each depth zone; nearer zones draw larger.
  function automatic logic [6:0] ball_size(input logic [4:0] zone);
    logic [6:0] s;
    case (zone)
      5'd0:    s = 7'd69;
      5'd1:    s = 7'd60;
      5'd2:    s = 7'd53;
      5'd3:    s = 7'd48;
      5'd4:    s = 7'd43;
      5'd5:    s = 7'd39;
      5'd6:    s = 7'd36;
      5'd7:    s = 7'd33;
      5'd8:    s = 7'd31;
      5'd9:    s = 7'd29;
      5'd10:   s = 7'd27;
      5'd11:   s = 7'd26;
      5'd12:   s = 7'd24;
      5'd13:   s = 7'd23;
      5'd14:   s = 7'd22;
      5'd15:   s = 7'd21;
      5'd16:   s = 7'd20;
      5'd17:   s = 7'd19;
      5'd18:   s = 7'd18;
      default: s = 7'd17;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/ball_frame_latch_if.sv
// Ball-centre update channel from game logic into ball_frame_latch.
interface ball_frame_latch_if;
  // Handshake: a transfer happens on every rising clk edge where in_valid and
  // in_ready are both high; in_x/in_y/in_z are only meaningful while in_valid.
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_x;
  logic [15:0] in_y;
  logic [15:0] in_z;

  modport master (output in_valid, output in_x, output in_y, output in_z,
                  input  in_ready);
  modport slave  (input  in_valid, input  in_x, input  in_y, input  in_z,
                  output in_ready);
endinterface

// File: rtl/ball_zone_div.sv
// Iterative depth-to-zone divider: one subtraction of Z_STEP per cycle,
// saturating at the last zone. done_o is high in the cycle the zone is final.
module ball_zone_div
  import curveball_pkg::*;
#(
  parameter int Z_STEP_P    = Z_STEP,
  parameter int NUM_ZONES_P = NUM_ZONES
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic [15:0] z_i,
  output logic        done_o,
  output logic [4:0]  zone_o
);

  localparam logic [15:0] STEP      = 16'(Z_STEP_P);
  localparam logic [4:0]  LAST_ZONE = 5'(NUM_ZONES_P - 1);

  logic [15:0] rem_q, rem_d;
  logic [4:0]  zone_q, zone_d;
  logic        busy_q, busy_d;
  logic        at_end;

  assign at_end = (rem_q < STEP) || (zone_q == LAST_ZONE);
  assign done_o = busy_q && at_end;
  assign zone_o = zone_q;

  always_comb begin
    rem_d  = rem_q;
    zone_d = zone_q;
    busy_d = busy_q;
    if (start_i) begin
      rem_d  = z_i;
      zone_d = 5'd0;
      busy_d = 1'b1;
    end else if (busy_q) begin
      if (at_end) begin
        busy_d = 1'b0;
      end else begin
        rem_d  = rem_q - STEP;
        zone_d = zone_q + 5'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q  <= 16'd0;
      zone_q <= 5'd0;
      busy_q <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      zone_q <= zone_d;
      busy_q <= busy_d;
    end
  end

endmodule

// File: rtl/ball_frame_latch.sv
// Frame-synchronous ball position stage: converts a ball centre to a sprite
// corner and applies it only on entry to vertical blank. Optional BALL_CLAMP_EN.
module ball_frame_latch
  import curveball_pkg::*;
#(
  parameter int H_ACTIVE_P  = H_ACTIVE,
  parameter int V_ACTIVE_P  = V_ACTIVE,
  parameter int Z_STEP_P    = Z_STEP,
  parameter int NUM_ZONES_P = NUM_ZONES
) (
  input  logic                     clk,
  input  logic                     rst,
  ball_frame_latch_if.slave        in_if,
  input  logic [15:0]              pixel_y,
  output logic [15:0]              x_loc,
  output logic [15:0]              y_loc,
  output logic [15:0]              z_loc,
  output logic [4:0]               zone,
  output logic                     frame_commit,
  output logic [7:0]               overrun_cnt,
  output ball_state_e              dbg_state_o
);

  ball_state_e state_q, state_d;

  logic [15:0] cap_x_q, cap_x_d, cap_y_q, cap_y_d, cap_z_q, cap_z_d;
  logic [15:0] pend_x_q, pend_x_d, pend_y_q, pend_y_d, pend_z_q, pend_z_d;
  logic [4:0]  pend_zone_q, pend_zone_d;
  logic [15:0] x_loc_q, x_loc_d, y_loc_q, y_loc_d, z_loc_q, z_loc_d;
  logic [4:0]  zone_q, zone_d;
  logic        commit_q, commit_d;
  logic [7:0]  ovr_q, ovr_d;
  logic [15:0] pixel_y_q;

  logic        take;
  logic        blank_edge;
  logic        div_done;
  logic [4:0]  div_zone;
  logic [6:0]  size;
  logic [15:0] half;
  logic [15:0] corner_x, corner_y;

  assign in_if.in_ready = (state_q == ST_IDLE) || (state_q == ST_WAIT_FRAME);
  assign take           = in_if.in_valid && in_if.in_ready;
  assign blank_edge     = (pixel_y_q != pixel_y) && (pixel_y == 16'(V_ACTIVE_P));

  ball_zone_div #(
    .Z_STEP_P    (Z_STEP_P),
    .NUM_ZONES_P (NUM_ZONES_P)
  ) u_div (
    .clk     (clk),
    .rst     (rst),
    .start_i (take),
    .z_i     (in_if.in_z),
    .done_o  (div_done),
    .zone_o  (div_zone)
  );

  assign size = ball_size(div_zone);
  assign half = {10'd0, size[6:1]};

`ifdef BALL_CLAMP_EN
  // Keep the whole sprite on-screen; a negative corner pins to 0.
  logic signed [17:0] raw_x, raw_y, hi_x, hi_y;
  always_comb begin
    raw_x    = $signed({2'b00, cap_x_q}) - $signed({2'b00, half});
    raw_y    = $signed({2'b00, cap_y_q}) - $signed({2'b00, half});
    hi_x     = $signed(18'(H_ACTIVE_P - 1)) - $signed({11'd0, size});
    hi_y     = $signed(18'(V_ACTIVE_P - 1)) - $signed({11'd0, size});
    corner_x = raw_x[15:0];
    corner_y = raw_y[15:0];
    if (raw_x[17])        corner_x = 16'd0;
    else if (raw_x > hi_x) corner_x = hi_x[15:0];
    if (raw_y[17])        corner_y = 16'd0;
    else if (raw_y > hi_y) corner_y = hi_y[15:0];
  end
`else
  assign corner_x = cap_x_q - half;
  assign corner_y = cap_y_q - half;
`endif

  always_comb begin
    state_d     = state_q;
    cap_x_d     = cap_x_q;
    cap_y_d     = cap_y_q;
    cap_z_d     = cap_z_q;
    pend_x_d    = pend_x_q;
    pend_y_d    = pend_y_q;
    pend_z_d    = pend_z_q;
    pend_zone_d = pend_zone_q;
    x_loc_d     = x_loc_q;
    y_loc_d     = y_loc_q;
    z_loc_d     = z_loc_q;
    zone_d      = zone_q;
    commit_d    = 1'b0;
    ovr_d       = ovr_q;
    if (take) begin
      cap_x_d = in_if.in_x;
      cap_y_d = in_if.in_y;
      cap_z_d = in_if.in_z;
    end
    case (state_q)
      ST_IDLE: begin
        if (take) state_d = ST_CONVERT;
      end
      ST_CONVERT: begin
        if (div_done) begin
          pend_x_d    = corner_x;
          pend_y_d    = corner_y;
          pend_z_d    = cap_z_q;
          pend_zone_d = div_zone;
          state_d     = ST_WAIT_FRAME;
        end
      end
      ST_WAIT_FRAME: begin
        if (blank_edge) begin
          x_loc_d  = pend_x_q;
          y_loc_d  = pend_y_q;
          z_loc_d  = pend_z_q;
          zone_d   = pend_zone_q;
          commit_d = 1'b1;
          state_d  = take ? ST_CONVERT : ST_IDLE;
        end else if (take) begin
          // A pending value replaced before it could be shown is an overrun.
          if (ovr_q != 8'hFF) ovr_d = ovr_q + 8'd1;
          state_d = ST_CONVERT;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cap_x_q     <= 16'd0;
      cap_y_q     <= 16'd0;
      cap_z_q     <= 16'd0;
      pend_x_q    <= 16'd0;
      pend_y_q    <= 16'd0;
      pend_z_q    <= 16'd0;
      pend_zone_q <= 5'd0;
      x_loc_q     <= 16'd0;
      y_loc_q     <= 16'd0;
      z_loc_q     <= 16'd0;
      zone_q      <= 5'd0;
      commit_q    <= 1'b0;
      ovr_q       <= 8'd0;
      pixel_y_q   <= 16'd0;
    end else begin
      state_q     <= state_d;
      cap_x_q     <= cap_x_d;
      cap_y_q     <= cap_y_d;
      cap_z_q     <= cap_z_d;
      pend_x_q    <= pend_x_d;
      pend_y_q    <= pend_y_d;
      pend_z_q    <= pend_z_d;
      pend_zone_q <= pend_zone_d;
      x_loc_q     <= x_loc_d;
      y_loc_q     <= y_loc_d;
      z_loc_q     <= z_loc_d;
      zone_q      <= zone_d;
      commit_q    <= commit_d;
      ovr_q       <= ovr_d;
      pixel_y_q   <= pixel_y;
    end
  end

  assign x_loc        = x_loc_q;
  assign y_loc        = y_loc_q;
  assign z_loc        = z_loc_q;
  assign zone         = zone_q;
  assign frame_commit = commit_q;
  assign overrun_cnt  = ovr_q;
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_ball_frame_latch.sv
// Self-checking bench for ball_frame_latch: committed outputs are checked
// against an expected queue filled when updates are driven.
module tb_ball_frame_latch;
  import curveball_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] pixel_y = 16'd0;
  logic [15:0] x_loc, y_loc, z_loc;
  logic [4:0]  zone;
  logic        frame_commit;
  logic [7:0]  overrun_cnt;
  ball_state_e dbg_state;

  ball_frame_latch_if bus ();

  ball_frame_latch dut (
    .clk          (clk),
    .rst          (rst),
    .in_if        (bus),
    .pixel_y      (pixel_y),
    .x_loc        (x_loc),
    .y_loc        (y_loc),
    .z_loc        (z_loc),
    .zone         (zone),
    .frame_commit (frame_commit),
    .overrun_cnt  (overrun_cnt),
    .dbg_state_o  (dbg_state)
  );

  // clock / reset block
  always #5 clk = ~clk;

  logic [52:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int exp_ovr  = 0;
  int size_tab [20] = '{69, 60, 53, 48, 43, 39, 36, 33, 31, 29,
                        27, 26, 24, 23, 22, 21, 20, 19, 18, 17};

  function automatic logic [52:0] model(input int x, input int y, input int z);
    int zn, sz, cx, cy;
    zn = z / 50;
    if (zn > 19) zn = 19;
    sz = size_tab[zn];
    cx = x - sz / 2;
    cy = y - sz / 2;
`ifdef BALL_CLAMP_EN
    if (cx < 0) cx = 0;
    if (cx > 639 - sz) cx = 639 - sz;
    if (cy < 0) cy = 0;
    if (cy > 479 - sz) cy = 479 - sz;
`endif
    return {16'(cx), 16'(cy), 16'(z), 5'(zn)};
  endfunction

  // Advance one clock; any frame_commit is matched against the expected queue.
  task automatic tick();
    logic [52:0] e;
    @(posedge clk);
    #1;
    if (frame_commit === 1'b1) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL commit_unexpected: got x=%0d y=%0d z=%0d zone=%0d, required no commit",
                 x_loc, y_loc, z_loc, zone);
      end else begin
        e = exp_q.pop_front();
        if ({x_loc, y_loc, z_loc, zone} !== e) begin
          n_fail++;
          $display("FAIL commit_value: got x=%0d y=%0d z=%0d zone=%0d, required x=%0d y=%0d z=%0d zone=%0d",
                   x_loc, y_loc, z_loc, zone, e[52:37], e[36:21], e[20:5], e[4:0]);
        end
      end
    end
  endtask

  // driver tasks
  task automatic send(input int x, input int y, input int z, input bit push);
    bus.in_valid = 1'b1;
    bus.in_x     = 16'(x);
    bus.in_y     = 16'(y);
    bus.in_z     = 16'(z);
    if (push) exp_q.push_back(model(x, y, z));
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_ready(output int cycles);
    cycles = 0;
    while (bus.in_ready !== 1'b1 && cycles < 100) begin
      cycles++;
      tick();
    end
    if (cycles >= 100) begin
      n_checks++;
      n_fail++;
      $display("FAIL ready_timeout: got in_ready=%b after %0d cycles, required 1", bus.in_ready, cycles);
    end
  endtask

  task automatic frame();
    pixel_y = 16'd479;
    tick();
    pixel_y = 16'd480;
    tick();
    pixel_y = 16'd0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    pixel_y = 16'd100;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    n_checks++;
    if ({x_loc, y_loc, z_loc, zone, frame_commit, overrun_cnt} !== 62'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got x=%0d y=%0d z=%0d zone=%0d fc=%b ovr=%0d, required all 0",
               x_loc, y_loc, z_loc, zone, frame_commit, overrun_cnt);
    end
    n_checks++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready: got %b, required 1", bus.in_ready);
    end
    frame();
    n_checks++;
    if (x_loc !== 16'd0) begin
      n_fail++;
      $display("FAIL idle_blank_hold: got x_loc=%0d, required 0", x_loc);
    end
  endtask

  task automatic test_basic();
    send(320, 240, 0, 1'b1);
    n_checks++;
    if (bus.in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_busy: got in_ready=%b, required 0", bus.in_ready);
    end
    tick();
    n_checks++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_ready_back: got in_ready=%b, required 1", bus.in_ready);
    end
    frame();
    n_checks++;
    if (x_loc !== 16'd286 || y_loc !== 16'd206 || zone !== 5'd0) begin
      n_fail++;
      $display("FAIL basic_corner: got x=%0d y=%0d zone=%0d, required 286 206 0", x_loc, y_loc, zone);
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL basic_pending: got %0d uncommitted, required 0", exp_q.size());
    end
    tick();
  endtask

  task automatic test_far();
    int cyc;
    send(100, 100, 975, 1'b1);
    n_checks++;
    if (dbg_state !== ST_CONVERT) begin
      n_fail++;
      $display("FAIL far_state: got %0d, required %0d", dbg_state, ST_CONVERT);
    end
    wait_ready(cyc);
    n_checks++;
    if (cyc != 20) begin
      n_fail++;
      $display("FAIL far_convert_len: got %0d cycles, required 20", cyc);
    end
    frame();
    n_checks++;
    if (x_loc !== 16'd92 || y_loc !== 16'd92 || zone !== 5'd19) begin
      n_fail++;
      $display("FAIL far_corner: got x=%0d y=%0d zone=%0d, required 92 92 19", x_loc, y_loc, zone);
    end
  endtask

  task automatic test_overrun();
    int cyc;
    send(50, 60, 120, 1'b0);
    wait_ready(cyc);
    send(200, 150, 500, 1'b1);
    exp_ovr++;
    n_checks++;
    if (int'(overrun_cnt) != exp_ovr) begin
      n_fail++;
      $display("FAIL overrun_count: got %0d, required %0d", overrun_cnt, exp_ovr);
    end
    wait_ready(cyc);
    frame();
    n_checks++;
    if (zone !== 5'd10 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL overrun_commit: got zone=%0d pending=%0d, required zone=10 pending=0", zone, exp_q.size());
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    send(300, 200, 250, 1'b1);
    wait_ready(cyc);
    pixel_y = 16'd479;
    tick();
    pixel_y = 16'd480;
    send(400, 300, 700, 1'b1);
    pixel_y = 16'd0;
    n_checks++;
    if (int'(overrun_cnt) != exp_ovr || bus.in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_same_edge: got ovr=%0d ready=%b, required ovr=%0d ready=0",
               overrun_cnt, bus.in_ready, exp_ovr);
    end
    n_checks++;
    if (exp_q.size() != 1) begin
      n_fail++;
      $display("FAIL b2b_old_commit: got %0d pending, required 1", exp_q.size());
    end
    wait_ready(cyc);
    frame();
    n_checks++;
    if (exp_q.size() != 0 || zone !== 5'd14) begin
      n_fail++;
      $display("FAIL b2b_new_commit: got pending=%0d zone=%0d, required 0 and 14", exp_q.size(), zone);
    end
  endtask

  task automatic test_blank_in_convert();
    int cyc;
    send(10, 20, 975, 1'b0);
    frame();
    n_checks++;
    if (dbg_state !== ST_CONVERT || zone !== 5'd14) begin
      n_fail++;
      $display("FAIL convert_blank: got state=%0d zone=%0d, required %0d and 14", dbg_state, zone, ST_CONVERT);
    end
    exp_q.push_back(model(10, 20, 975));
    wait_ready(cyc);
    frame();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL convert_next_frame: got %0d pending, required 0", exp_q.size());
    end
  endtask

  task automatic test_underflow();
    int cyc;
    logic [15:0] want;
`ifdef BALL_CLAMP_EN
    want = 16'd0;
`else
    want = 16'd65507;
`endif
    send(5, 200, 0, 1'b1);
    wait_ready(cyc);
    frame();
    n_checks++;
    if (x_loc !== want) begin
      n_fail++;
      $display("FAIL underflow_x: got %0d, required %0d", x_loc, want);
    end
  endtask

  task automatic test_mid_reset();
    send(100, 100, 500, 1'b0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_ovr = 0;
    n_checks++;
    if ({x_loc, y_loc, z_loc, zone, overrun_cnt} !== 61'd0 || bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_reset: got x=%0d y=%0d z=%0d zone=%0d ovr=%0d ready=%b, required zeros and ready=1",
               x_loc, y_loc, z_loc, zone, overrun_cnt, bus.in_ready);
    end
    tick();
    frame();
    n_checks++;
    if (x_loc !== 16'd0) begin
      n_fail++;
      $display("FAIL mid_reset_discard: got x_loc=%0d, required 0", x_loc);
    end
  endtask

  task automatic test_random();
    int cyc, x, y, z;
    for (int i = 0; i < 6; i++) begin
      x = $urandom_range(0, 639);
      y = $urandom_range(0, 479);
      z = $urandom_range(0, 1200);
      send(x, y, z, 1'b1);
      wait_ready(cyc);
      frame();
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL random_drain: got %0d pending, required 0", exp_q.size());
    end
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_x     = 16'd0;
    bus.in_y     = 16'd0;
    bus.in_z     = 16'd0;
    test_reset();
    test_basic();
    test_far();
    test_overrun();
    test_back_to_back();
    test_blank_in_convert();
    test_underflow();
    test_random();
    test_mid_reset();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL final_queue: got %0d pending, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
